prog_loader_stream: RTL and testbench
=====================================

Name: prog_loader_stream

Overview:
- Parametrised boot loader for the RIDE out-of-order core. It is the successor to the hard-wired `prog_loading` / `prog_loadaddr` / `prog_loaddata` path in the top level.
- Accepts a 32-bit word stream with a valid/ready handshake. Packs words into FETCH_WIDTH-wide instruction-memory lines, then writes a block of data-memory words.
- Holds the pipeline in reset until loading completes, and drives the imem/dmem write-side multiplexers in the top level.

Parameters:
- INSN_LEN, 32, width of one stream word / instruction / dmem word
- FETCH_WIDTH, 4, instructions per imem line (line width = FETCH_WIDTH*INSN_LEN)
- IMEM_AW, 9, imem line-address width
- DMEM_AW, 30, dmem word-address width
- IMEM_LINES, 512, imem lines to load (1..2**IMEM_AW)
- DMEM_WORDS, 0, dmem words to load after imem (0..2**DMEM_AW; 0 skips the dmem phase)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a load; sampled in IDLE and DONE only
- in_valid  in  1  stream word valid
- in_ready  out  1  loader accepts a word this cycle
- in_data  in  INSN_LEN  stream word
- loading  out  1  high while the loader owns the memories; selects the loader side of the imem/dmem muxes
- core_reset  out  1  pipeline reset request; ORed with the external reset at the top level
- imem_we  out  1  imem line write strobe
- imem_addr  out  IMEM_AW  imem line index
- imem_wdata  out  FETCH_WIDTH*INSN_LEN  packed line
- dmem_we  out  1  dmem word write strobe
- dmem_addr  out  DMEM_AW  dmem word index
- dmem_wdata  out  INSN_LEN  dmem word
- done  out  1  load complete
- err  out  1  checksum mismatch (constant 0 when the optional feature is compiled out)

Behaviour:
- Reset values: state = IDLE, all counters = 0, line buffer = 0.
  - Outputs: in_ready = 0, loading = 0, core_reset = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0, done = 0, err = 0.
- States and transitions:
  - IDLE -> L_IMEM on start.
  - L_IMEM -> L_DMEM when the last word of line IMEM_LINES-1 is accepted, or -> CHK / DONE if DMEM_WORDS = 0.
  - L_DMEM -> CHK / DONE when word DMEM_WORDS-1 is accepted.
  - DONE -> L_IMEM on start (reload).
- Output levels by state:
  - in_ready = 1 in L_IMEM, L_DMEM and CHK; 0 otherwise.
  - loading = 1 in L_IMEM, L_DMEM and CHK, and for the single write-flush cycle after them.
- Handshake: a beat transfers when in_valid & in_ready. No back-pressure stalls inside a state; in_ready is a function of state only.
- Packing: beat k (k = 0..FETCH_WIDTH-1) of a line is placed at bits [(k+1)*INSN_LEN-1 : k*INSN_LEN]. Unused slots are never partially written.
- Imem write latency: on the cycle after the beat completing a line, imem_we = 1 for exactly one cycle. imem_addr = line counter and imem_wdata = full line, both registered. The line counter then increments.
- Dmem write latency: on the cycle after each accepted beat in L_DMEM, dmem_we = 1 for one cycle with dmem_addr = word counter and dmem_wdata = that word.
- Address hold: addresses and write data hold their last values when the strobes are low.
- Counter wrap: counters never wrap inside a load. Loading IMEM_LINES = 2**IMEM_AW lines ends at line 2**IMEM_AW-1 without overflow. All counters clear when entering L_IMEM.
- core_reset: 1 in every state except DONE. It falls in the cycle DONE is entered, which is after the final write strobe has been issued. It rises again when a reload starts.
- done: 1 only in DONE.
- start while loading: ignored.
- reset mid-load: returns to IDLE immediately. The partial line is discarded and no strobe is issued on the reset cycle or the cycle after.
- Simultaneous start and in_valid in IDLE: start is taken; the beat is not accepted (in_ready = 0).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - After the last data beat the loader enters CHK and accepts one extra word.
  - This word must equal the modulo 2**INSN_LEN sum of all imem and dmem words in the load.
  - Match -> DONE.
  - Mismatch -> ERR: err = 1, core_reset stays 1, in_ready = 0. ERR is left only by reset or start (start -> L_IMEM, err cleared).
- When undefined: no CHK or ERR states, err tied to 0, and the last data beat goes straight to DONE.

Test Plan:
- Basic load, IMEM_LINES = 2, DMEM_WORDS = 0:
  - Stimulus: start, then words 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88.
  - Required: imem_we pulses with addr 0 / data 0x00000044_00000033_00000022_00000011, then addr 1 / data 0x..88_77_66_55. done = 1, and core_reset falls after the second strobe.
- Dmem phase, DMEM_WORDS = 3, IMEM_LINES = 1:
  - Stimulus: 4 imem words, then data words 0xA, 0xB, 0xC.
  - Required: dmem_we pulses at addr 0, 1, 2 with wdata 0xA, 0xB, 0xC, each one cycle after acceptance.
- Gappy stream: in_valid toggles 1,0,0,1,...
  - Required: strobes occur only after complete lines; no beat is lost or duplicated, and the final image matches the gapless case.
- Reset mid-line: assert reset after 2 beats of line 0.
  - Required: no imem_we; next cycle state = IDLE with core_reset = 1, done = 0.
  - Required: a following start and full load writes from addr 0.
- Reload from DONE: pulse start.
  - Required: core_reset rises the next cycle, counters restart at 0, and start during L_IMEM is ignored.
- LOADER_CHECKSUM_EN, checksum check:
  - Stimulus: words 1, 2, 3, 4 then checksum 10 -> done = 1.
  - Stimulus: checksum 11 -> err = 1, done = 0, core_reset = 1.

Source files
------------

// File: rtl/prog_loader_stream.sv
// Boot loader: packs a 32-bit word stream into imem lines, then writes a dmem block.
// Optional trailing checksum word when LOADER_CHECKSUM_EN is defined.
module prog_loader_stream #(
   parameter int INSN_LEN    = 32,
   parameter int FETCH_WIDTH = 4,
   parameter int IMEM_AW     = 9,
   parameter int DMEM_AW     = 30,
   parameter int IMEM_LINES  = 512,
   parameter int DMEM_WORDS  = 0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [INSN_LEN-1:0]             in_data,
   output logic                            loading,
   output logic                            core_reset,
   output logic                            imem_we,
   output logic [IMEM_AW-1:0]              imem_addr,
   output logic [FETCH_WIDTH*INSN_LEN-1:0] imem_wdata,
   output logic                            dmem_we,
   output logic [DMEM_AW-1:0]              dmem_addr,
   output logic [INSN_LEN-1:0]             dmem_wdata,
   output logic                            done,
   output logic                            err
);

   localparam int LINE_W = FETCH_WIDTH * INSN_LEN;
   localparam int BEAT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(FETCH_WIDTH - 1);
   localparam logic [IMEM_AW-1:0] LAST_LINE = IMEM_AW'(IMEM_LINES - 1);
   localparam logic [DMEM_AW-1:0] LAST_WORD = DMEM_AW'((DMEM_WORDS > 0) ? DMEM_WORDS - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      L_IMEM,
      L_DMEM,
`ifdef LOADER_CHECKSUM_EN
      CHK,
      ERR,
`endif
      FLUSH,
      DONE
   } state_t;

   // Where the final data beat leads: checksum word or straight to the write flush.
`ifdef LOADER_CHECKSUM_EN
   localparam state_t DATA_END = CHK;
`else
   localparam state_t DATA_END = FLUSH;
`endif

   state_t               state_q, state_d;
   logic [BEAT_W-1:0]    beatCnt_q, beatCnt_d;
   logic [IMEM_AW-1:0]   lineCnt_q, lineCnt_d;
   logic [DMEM_AW-1:0]   wordCnt_q, wordCnt_d;
   logic [LINE_W-1:0]    lineBuf_q, lineBuf_d, lineIns;
   logic                 imemWe_q, imemWe_d;
   logic [IMEM_AW-1:0]   imemAddr_q, imemAddr_d;
   logic [LINE_W-1:0]    imemWdata_q, imemWdata_d;
   logic                 dmemWe_q, dmemWe_d;
   logic [DMEM_AW-1:0]   dmemAddr_q, dmemAddr_d;
   logic [INSN_LEN-1:0]  dmemWdata_q, dmemWdata_d;
   logic                 inReady_q, loading_q, coreReset_q, done_q;
   logic                 fire, canStart;
`ifdef LOADER_CHECKSUM_EN
   logic [INSN_LEN-1:0]  sum_q, sum_d;
   logic                 err_q;
`endif

   always_comb begin
      state_d     = state_q;
      beatCnt_d   = beatCnt_q;
      lineCnt_d   = lineCnt_q;
      wordCnt_d   = wordCnt_q;
      lineBuf_d   = lineBuf_q;
      imemWe_d    = 1'b0;
      imemAddr_d  = imemAddr_q;
      imemWdata_d = imemWdata_q;
      dmemWe_d    = 1'b0;
      dmemAddr_d  = dmemAddr_q;
      dmemWdata_d = dmemWdata_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif
      fire     = in_valid & inReady_q;
      canStart = (state_q == IDLE) || (state_q == DONE)
`ifdef LOADER_CHECKSUM_EN
                 || (state_q == ERR)
`endif
                 ;

      lineIns = lineBuf_q;
      for (int k = 0; k < FETCH_WIDTH; k++)
         if (beatCnt_q == BEAT_W'(k)) lineIns[k*INSN_LEN +: INSN_LEN] = in_data;

      if (canStart && start) begin
         state_d   = L_IMEM;
         beatCnt_d = '0;
         lineCnt_d = '0;
         wordCnt_d = '0;
         lineBuf_d = '0;
`ifdef LOADER_CHECKSUM_EN
         sum_d     = '0;
`endif
      end else begin
         case (state_q)
            L_IMEM: if (fire) begin
`ifdef LOADER_CHECKSUM_EN
               sum_d = sum_q + in_data;
`endif
               if (beatCnt_q == LAST_BEAT) begin
                  beatCnt_d   = '0;
                  lineBuf_d   = '0;
                  imemWe_d    = 1'b1;
                  imemAddr_d  = lineCnt_q;
                  imemWdata_d = lineIns;
                  // The last line leaves the counter in place so a full-depth load never wraps.
                  if (lineCnt_q == LAST_LINE)
                     state_d = (DMEM_WORDS == 0) ? DATA_END : L_DMEM;
                  else
                     lineCnt_d = lineCnt_q + IMEM_AW'(1);
               end else begin
                  beatCnt_d = beatCnt_q + BEAT_W'(1);
                  lineBuf_d = lineIns;
               end
            end
            L_DMEM: if (fire) begin
`ifdef LOADER_CHECKSUM_EN
               sum_d = sum_q + in_data;
`endif
               dmemWe_d    = 1'b1;
               dmemAddr_d  = wordCnt_q;
               dmemWdata_d = in_data;
               if (wordCnt_q == LAST_WORD) state_d = DATA_END;
               else wordCnt_d = wordCnt_q + DMEM_AW'(1);
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: if (fire) state_d = (in_data == sum_q) ? FLUSH : ERR;
`endif
            FLUSH:   state_d = DONE;
            default: ;
         endcase
      end
   end

   // Outputs are registered decodes of the next state so they change with the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         beatCnt_q   <= '0;
         lineCnt_q   <= '0;
         wordCnt_q   <= '0;
         lineBuf_q   <= '0;
         imemWe_q    <= 1'b0;
         imemAddr_q  <= '0;
         imemWdata_q <= '0;
         dmemWe_q    <= 1'b0;
         dmemAddr_q  <= '0;
         dmemWdata_q <= '0;
         inReady_q   <= 1'b0;
         loading_q   <= 1'b0;
         coreReset_q <= 1'b1;
         done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         beatCnt_q   <= beatCnt_d;
         lineCnt_q   <= lineCnt_d;
         wordCnt_q   <= wordCnt_d;
         lineBuf_q   <= lineBuf_d;
         imemWe_q    <= imemWe_d;
         imemAddr_q  <= imemAddr_d;
         imemWdata_q <= imemWdata_d;
         dmemWe_q    <= dmemWe_d;
         dmemAddr_q  <= dmemAddr_d;
         dmemWdata_q <= dmemWdata_d;
`ifdef LOADER_CHECKSUM_EN
         inReady_q   <= (state_d == L_IMEM) || (state_d == L_DMEM) || (state_d == CHK);
         loading_q   <= (state_d == L_IMEM) || (state_d == L_DMEM) || (state_d == CHK) ||
                        (state_d == FLUSH);
         sum_q       <= sum_d;
         err_q       <= (state_d == ERR);
`else
         inReady_q   <= (state_d == L_IMEM) || (state_d == L_DMEM);
         loading_q   <= (state_d == L_IMEM) || (state_d == L_DMEM) || (state_d == FLUSH);
`endif
         coreReset_q <= (state_d != DONE);
         done_q      <= (state_d == DONE);
      end
   end

   // Strobes are masked during reset so a line completed just before reset is dropped.
   assign imem_we    = imemWe_q & ~reset;
   assign dmem_we    = dmemWe_q & ~reset;
   assign imem_addr  = imemAddr_q;
   assign imem_wdata = imemWdata_q;
   assign dmem_addr  = dmemAddr_q;
   assign dmem_wdata = dmemWdata_q;
   assign in_ready   = inReady_q;
   assign loading    = loading_q;
   assign core_reset = coreReset_q;
   assign done       = done_q;
`ifdef LOADER_CHECKSUM_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader_stream.sv
// Directed bench for prog_loader_stream: 2 imem lines (full 1-bit address space), 3 dmem words.
// Honours LOADER_CHECKSUM_EN when the design is built with it.
module tb_prog_loader_stream;

   logic         clk;
   logic         reset;
   logic         start;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic         loading;
   logic         core_reset;
   logic         imem_we;
   logic [0:0]   imem_addr;
   logic [127:0] imem_wdata;
   logic         dmem_we;
   logic [3:0]   dmem_addr;
   logic [31:0]  dmem_wdata;
   logic         done;
   logic         err;

   int checks = 0;
   int errors = 0;

   prog_loader_stream #(
      .INSN_LEN(32), .FETCH_WIDTH(4), .IMEM_AW(1), .DMEM_AW(4),
      .IMEM_LINES(2), .DMEM_WORDS(3)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .loading(loading), .core_reset(core_reset),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Present one word from a falling edge and hold it until a rising edge takes it.
   task automatic applyStimulus(input logic [31:0] w, output bit ok);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = (in_ready === 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic startLoad(input bit withValid, input logic [31:0] junk);
      start    = 1'b1;
      in_valid = withValid;
      in_data  = junk;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || loading !== 1'b1 || core_reset !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL start_entry: ready/loading/core_reset/done got %b%b%b%b expected 1110",
                  in_ready, loading, core_reset, done);
      end
   endtask

   // Full load of 8 imem words base*(1..8) and dmem words 0xA,0xB,0xC.
   task automatic runLoad(input int gap, input logic [31:0] base, input bit goodSum,
                          input int startBeat);
      logic [127:0] line;
      logic [31:0]  w, sum;
      logic [0:0]   la;
      bit           ok;
      sum = 0;
      for (int l = 0; l < 2; l++) begin
         line = '0;
         la   = 1'(l);
         for (int k = 0; k < 4; k++) begin
            w = base * (l * 4 + k + 1);
            sum = sum + w;
            line[k*32 +: 32] = w;
            if (l == 0 && k == startBeat) start = 1'b1;
            applyStimulus(w, ok);
            start = 1'b0;
            checks++;
            if (!ok) begin
               errors++;
               $display("[TB] FAIL accept_timeout: word %h not accepted, expected acceptance", w);
            end
            checks++;
            if (k == 3) begin
               if (imem_we !== 1'b1 || imem_addr !== la || imem_wdata !== line) begin
                  errors++;
                  $display("[TB] FAIL imem_write: we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                           imem_we, imem_addr, imem_wdata, la, line);
               end
            end else if (imem_we !== 1'b0) begin
               errors++;
               $display("[TB] FAIL imem_we_idle: got %b expected 0 (line %0d beat %0d)", imem_we, l, k);
            end
            for (int g = 0; g < gap; g++) begin
               @(negedge clk);
               checks++;
               if (imem_we !== 1'b0 || dmem_we !== 1'b0) begin
                  errors++;
                  $display("[TB] FAIL gap_strobe: imem_we=%b dmem_we=%b expected 0 0", imem_we, dmem_we);
               end
            end
         end
      end
      for (int j = 0; j < 3; j++) begin
         w = 32'hA + j;
         sum = sum + w;
         applyStimulus(w, ok);
         checks++;
         if (!ok || dmem_we !== 1'b1 || imem_we !== 1'b0 || dmem_addr !== 4'(j) || dmem_wdata !== w) begin
            errors++;
            $display("[TB] FAIL dmem_write: ok=%b we=%b imem_we=%b addr=%h data=%h expected 1 1 0 %h %h",
                     ok, dmem_we, imem_we, dmem_addr, dmem_wdata, 4'(j), w);
         end
         if (j < 2)
            for (int g = 0; g < gap; g++) @(negedge clk);
      end
`ifdef LOADER_CHECKSUM_EN
      checks++;
      if (in_ready !== 1'b1 || core_reset !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL chk_state: ready/core_reset/done got %b%b%b expected 110",
                  in_ready, core_reset, done);
      end
      applyStimulus(goodSum ? sum : sum + 32'd1, ok);
      if (!goodSum) begin
         checks++;
         if (err !== 1'b1 || done !== 1'b0 || core_reset !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_checksum: err/done/core_reset/ready got %b%b%b%b expected 1010",
                     err, done, core_reset, in_ready);
         end
         return;
      end
`endif
      checks++;
      if (loading !== 1'b1 || core_reset !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_cycle: loading/core_reset/done/ready got %b%b%b%b expected 1100",
                  loading, core_reset, done, in_ready);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || core_reset !== 1'b0 || loading !== 1'b0 || err !== 1'b0 ||
          imem_we !== 1'b0 || dmem_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL done_state: done/core_reset/loading/err/iwe/dwe got %b%b%b%b%b%b expected 100000",
                  done, core_reset, loading, err, imem_we, dmem_we);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || loading !== 1'b0 || core_reset !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: ready/loading/core_reset/done/err got %b%b%b%b%b expected 00100",
                  in_ready, loading, core_reset, done, err);
      end
      checks++;
      if (imem_we !== 1'b0 || imem_addr !== 1'b0 || imem_wdata !== '0 ||
          dmem_we !== 1'b0 || dmem_addr !== 4'h0 || dmem_wdata !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mem: iwe=%b ia=%h id=%h dwe=%b da=%h dd=%h expected all 0",
                  imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata);
      end
   endtask

   // Start with a junk beat offered in the same cycle; the junk must not land in line 0.
   task automatic test_basic_load();
      startLoad(1'b1, 32'hDEAD_BEEF);
      runLoad(0, 32'h11, 1'b1, -1);
   endtask

   // Reload from DONE with a gappy stream and a stray start inside L_IMEM.
   task automatic test_reload_gappy();
      startLoad(1'b0, 32'h0);
      runLoad(2, 32'h11, 1'b1, 1);
   endtask

   task automatic test_reset_mid_line();
      bit ok;
      startLoad(1'b0, 32'h0);
      applyStimulus(32'h0000_0101, ok);
      applyStimulus(32'h0000_0202, ok);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b0 || in_ready !== 1'b0 || core_reset !== 1'b1 || done !== 1'b0 ||
          loading !== 1'b0 || imem_addr !== 1'b0 || dmem_addr !== 4'h0) begin
         errors++;
         $display("[TB] FAIL reset_mid: iwe/ready/core_reset/done/loading got %b%b%b%b%b ia=%h da=%h expected 00100 0 0",
                  imem_we, in_ready, core_reset, done, loading, imem_addr, dmem_addr);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b0 || in_ready !== 1'b0 || core_reset !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_after: iwe/ready/core_reset got %b%b%b expected 001",
                  imem_we, in_ready, core_reset);
      end
      startLoad(1'b0, 32'h0);
      runLoad(0, 32'h11, 1'b1, -1);
   endtask

   task automatic test_checksum();
`ifdef LOADER_CHECKSUM_EN
      startLoad(1'b0, 32'h0);
      runLoad(0, 32'h1, 1'b0, -1);
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || in_ready !== 1'b0 || core_reset !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_hold: err/ready/core_reset got %b%b%b expected 101", err, in_ready, core_reset);
      end
      startLoad(1'b0, 32'h0);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_clear: got %b expected 0", err);
      end
      runLoad(0, 32'h1, 1'b1, -1);
`else
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_tied: got %b expected 0", err);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_reload_gappy();
      test_reset_mid_line();
      test_checksum();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
